load_store_unit: RTL and testbench

Load/store unit that sits between the core's execute stage and the word-organised data memory, acting as the initiator of the memory's synchronous read / byte-enabled write port. It accepts one RV32I load or store request at a time, computes the effective address, checks alignment and range, and drives the memory's write enable, read enable, byte enable, address and data. On loads it holds the access across the memory's one-cycle registered read, then sign- or zero-extends the returned byte/halfword. The memory returns sub-word data already lane-shifted to bit 0, so this block only extends it.

---
 rtl/load_store_unit_if.sv | 42 ++++
 rtl/load_store_unit.sv | 185 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Signal bundle between load_store_unit, the core's execute stage and the data memory.
// The master side is the core plus memory; the slave side is the load/store unit itself.
interface load_store_unit_if #(
    parameter int ADDR_BITWIDTH = 10
);

    logic                     LSU_Req_Valid;
    logic                     LSU_Req_Ready;
    logic                     LSU_Req_Store;
    logic [2:0]               LSU_Req_Funct3;
    logic [31:0]              LSU_Req_Base;
    logic [31:0]              LSU_Req_Offset;
    logic [31:0]              LSU_Req_Wdata;

    logic                     LSU_Resp_Valid;
    logic [31:0]              LSU_Resp_Data;
    logic                     LSU_Resp_Error;

    logic                     LSU_Mem_We;
    logic                     LSU_Mem_Re;
    logic [3:0]               LSU_Mem_Byteenable;
    logic [ADDR_BITWIDTH-1:0] LSU_Mem_Address;
    logic [31:0]              LSU_Mem_Data_Out;
    logic [31:0]              LSU_Mem_Data_In;

    modport master (
        output LSU_Req_Valid, LSU_Req_Store, LSU_Req_Funct3, LSU_Req_Base,
               LSU_Req_Offset, LSU_Req_Wdata, LSU_Mem_Data_In,
        input  LSU_Req_Ready, LSU_Resp_Valid, LSU_Resp_Data, LSU_Resp_Error,
               LSU_Mem_We, LSU_Mem_Re, LSU_Mem_Byteenable, LSU_Mem_Address,
               LSU_Mem_Data_Out
    );

    modport slave (
        input  LSU_Req_Valid, LSU_Req_Store, LSU_Req_Funct3, LSU_Req_Base,
               LSU_Req_Offset, LSU_Req_Wdata, LSU_Mem_Data_In,
        output LSU_Req_Ready, LSU_Resp_Valid, LSU_Resp_Data, LSU_Resp_Error,
               LSU_Mem_We, LSU_Mem_Re, LSU_Mem_Byteenable, LSU_Mem_Address,
               LSU_Mem_Data_Out
    );

endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, alignment and range checking,
// a registered byte-enabled memory port, and sign/zero extension of load data.
module load_store_unit #(
    parameter int ADDR_BITWIDTH = 10
) (
    input  logic             LSU_Clk,
    input  logic             LSU_Reset,
    load_store_unit_if.slave lsu_bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STORE,
        S_LOAD_ADDR,
        S_LOAD_DATA,
        S_ERR,
        S_RESP
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_e                   state_q, state_d;
    logic [ADDR_BITWIDTH-1:0] addr_q, addr_d;
    logic [2:0]               funct3_q, funct3_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [31:0]              resp_data_q, resp_data_d;
    logic                     resp_error_q, resp_error_d;

    logic [31:0]              ea;
    logic                     funct3_legal;
    logic                     misaligned;
    logic                     out_of_range;
    logic                     req_error;
    logic [31:0]              wdata_masked;
    logic [3:0]               byteenable;
    logic [31:0]              load_ext;

    // Request decode, consulted only in the cycle a request is accepted.
    // NOTE: every case below ends in a default, so each variable is assigned on all paths and no latch is inferred.
    always_comb begin
        ea = lsu_bus.LSU_Req_Base + lsu_bus.LSU_Req_Offset;

        case (lsu_bus.LSU_Req_Funct3)
            F3_B, F3_H, F3_W: funct3_legal = 1'b1;
            F3_BU, F3_HU:     funct3_legal = !lsu_bus.LSU_Req_Store;
            default:          funct3_legal = 1'b0;
        endcase

        case (lsu_bus.LSU_Req_Funct3[1:0])
            2'b01:   misaligned = ea[0];
            2'b10:   misaligned = |ea[1:0];
            default: misaligned = 1'b0;
        endcase

        out_of_range = (ea >> ADDR_BITWIDTH) != 32'd0;
        req_error    = !funct3_legal || misaligned || out_of_range;

        case (lsu_bus.LSU_Req_Funct3[1:0])
            2'b00:   wdata_masked = {24'd0, lsu_bus.LSU_Req_Wdata[7:0]};
            2'b01:   wdata_masked = {16'd0, lsu_bus.LSU_Req_Wdata[15:0]};
            default: wdata_masked = lsu_bus.LSU_Req_Wdata;
        endcase
    end

    // Width and extension of the registered access.
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   byteenable = 4'b0001;
            2'b01:   byteenable = 4'b0011;
            2'b10:   byteenable = 4'b1111;
            default: byteenable = 4'b0000;
        endcase

        case (funct3_q)
            F3_B:    load_ext = {{24{lsu_bus.LSU_Mem_Data_In[7]}}, lsu_bus.LSU_Mem_Data_In[7:0]};
            F3_H:    load_ext = {{16{lsu_bus.LSU_Mem_Data_In[15]}}, lsu_bus.LSU_Mem_Data_In[15:0]};
            F3_BU:   load_ext = {24'd0, lsu_bus.LSU_Mem_Data_In[7:0]};
            F3_HU:   load_ext = {16'd0, lsu_bus.LSU_Mem_Data_In[15:0]};
            default: load_ext = lsu_bus.LSU_Mem_Data_In;
        endcase
    end

    // Memory outputs depend only on state_q and the request registers.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        resp_data_d  = resp_data_q;
        resp_error_d = resp_error_q;

        lsu_bus.LSU_Req_Ready      = 1'b0;
        lsu_bus.LSU_Resp_Valid     = 1'b0;
        lsu_bus.LSU_Mem_We         = 1'b0;
        lsu_bus.LSU_Mem_Re         = 1'b0;
        lsu_bus.LSU_Mem_Byteenable = 4'b0000;
        lsu_bus.LSU_Mem_Address    = '0;
        lsu_bus.LSU_Mem_Data_Out   = 32'd0;

        case (state_q)
            S_IDLE: begin
                lsu_bus.LSU_Req_Ready = 1'b1;
                if (lsu_bus.LSU_Req_Valid) begin
                    addr_d       = ea[ADDR_BITWIDTH-1:0];
                    funct3_d     = lsu_bus.LSU_Req_Funct3;
                    wdata_d      = wdata_masked;
                    resp_data_d  = 32'd0;
                    resp_error_d = 1'b0;
                    if (req_error) begin
                        state_d = S_ERR;
                    end else if (lsu_bus.LSU_Req_Store) begin
                        state_d = S_STORE;
                    end else begin
                        state_d = S_LOAD_ADDR;
                    end
                end
            end

            S_STORE: begin
                lsu_bus.LSU_Mem_We         = 1'b1;
                lsu_bus.LSU_Mem_Byteenable = byteenable;
                lsu_bus.LSU_Mem_Address    = addr_q;
                lsu_bus.LSU_Mem_Data_Out   = wdata_q;
                state_d                    = S_RESP;
            end

            S_LOAD_ADDR: begin
                lsu_bus.LSU_Mem_Re         = 1'b1;
                lsu_bus.LSU_Mem_Byteenable = byteenable;
                lsu_bus.LSU_Mem_Address    = addr_q;
                state_d                    = S_LOAD_DATA;
            end

            // Address is held so the memory sees a stable request across its registered read.
            S_LOAD_DATA: begin
                lsu_bus.LSU_Mem_Re         = 1'b1;
                lsu_bus.LSU_Mem_Byteenable = byteenable;
                lsu_bus.LSU_Mem_Address    = addr_q;
                resp_data_d                = load_ext;
                state_d                    = S_RESP;
            end

            S_ERR: begin
                resp_error_d = 1'b1;
                state_d      = S_RESP;
            end

            S_RESP: begin
                lsu_bus.LSU_Resp_Valid = 1'b1;
                state_d                = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign lsu_bus.LSU_Resp_Data  = resp_data_q;
    assign lsu_bus.LSU_Resp_Error = resp_error_q;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge LSU_Clk or posedge LSU_Reset) begin
        if (LSU_Reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            funct3_q     <= 3'd0;
            wdata_q      <= 32'd0;
            resp_data_q  <= 32'd0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit: the bench plays both the core and a
// registered byte-addressed data memory, and checks against a byte-array reference model.
module tb_load_store_unit;

    localparam int AW        = 10;
    localparam int MEM_BYTES = 1 << AW;
    localparam logic [95:0] RESET_OUTS = 96'd1 << 82;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_BITWIDTH(AW)) bus ();

    load_store_unit #(.ADDR_BITWIDTH(AW)) dut (
        .LSU_Clk   (clk),
        .LSU_Reset (rst),
        .lsu_bus   (bus)
    );

    typedef struct {
        bit          st;
        bit          err;
        logic [3:0]  be;
        logic [AW-1:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          acc_cyc;
        int          resp_edges;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] dev_mem [MEM_BYTES];
    logic [7:0] ref_mem [MEM_BYTES];
    int         n_cmp    = 0;
    int         n_bad    = 0;
    int         cyc      = 0;
    bit         b2b      = 1'b0;
    int         exp_busy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [95:0] outs();
        return {bus.LSU_Req_Ready, bus.LSU_Resp_Valid, bus.LSU_Resp_Error, bus.LSU_Resp_Data,
                bus.LSU_Mem_We, bus.LSU_Mem_Re, bus.LSU_Mem_Byteenable, bus.LSU_Mem_Address,
                bus.LSU_Mem_Data_Out};
    endfunction

    // Reference model: EA arithmetic and byte-array memory, little-endian lanes.
    function automatic exp_t model(input bit st, input logic [2:0] f3, input logic [31:0] base,
                                   input logic [31:0] off, input logic [31:0] wd, input bit live);
        exp_t        e;
        logic [31:0] ea, mask, v;
        int          n, a;
        bit          legal;
        ea    = base + off;
        legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n     = 1 << f3[1:0];
        mask  = (n >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        e.st    = st;
        e.err   = !legal || ((ea % n) != 0) || (ea >= MEM_BYTES);
        e.be    = 4'((1 << n) - 1);
        e.addr  = ea[AW-1:0];
        e.wdata = wd & mask;
        e.rdata = 32'd0;
        e.acc_cyc    = 0;
        e.resp_edges = (st || e.err) ? 1 : 2;
        a = int'(ea[AW-1:0]);
        if (!e.err) begin
            if (st) begin
                if (live) for (int i = 0; i < n; i++) ref_mem[a + i] = e.wdata[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + i];
                if (!f3[2] && n < 4 && v[8*n - 1]) v = v | ~mask;
                e.rdata = v;
            end
        end
        return e;
    endfunction

    // Memory device: registered read returning the access lanes at bit 0, random above.
    logic          dv_we, dv_re;
    logic [3:0]    dv_be;
    logic [AW-1:0] dv_addr;
    logic [31:0]   dv_data, dv_rd;
    always @(posedge clk) begin
        dv_we   = bus.LSU_Mem_We;
        dv_re   = bus.LSU_Mem_Re;
        dv_be   = bus.LSU_Mem_Byteenable;
        dv_addr = bus.LSU_Mem_Address;
        dv_data = bus.LSU_Mem_Data_Out;
        #1;
        if (dv_we)
            for (int i = 0; i < 4; i++)
                if (dv_be[i]) dev_mem[(int'(dv_addr) + i) % MEM_BYTES] = dv_data[8*i +: 8];
        if (dv_re) begin
            dv_rd = $urandom;
            for (int i = 0; i < 4; i++)
                if (dv_be[i]) dv_rd[8*i +: 8] = dev_mem[(int'(dv_addr) + i) % MEM_BYTES];
            bus.LSU_Mem_Data_In = dv_rd;
        end
    end

    // Monitor: memory-port activity is checked against the oldest outstanding request,
    // and each response pops and checks it.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.LSU_Mem_We || bus.LSU_Mem_Re) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL mem_access_unexpected: We=%0b Re=%0b with nothing outstanding (t=%0t)",
                             bus.LSU_Mem_We, bus.LSU_Mem_Re, $time);
                end else begin
                    mon_e = exp_q[0];
                    if (mon_e.err) begin
                        check("mem_access_on_error", {bus.LSU_Mem_We, bus.LSU_Mem_Re}, 2'b00);
                    end else begin
                        check("mem_port", {bus.LSU_Mem_We, bus.LSU_Mem_Re, bus.LSU_Mem_Byteenable, bus.LSU_Mem_Address},
                              {mon_e.st, !mon_e.st, mon_e.be, mon_e.addr});
                        if (mon_e.st) check("mem_data_out", bus.LSU_Mem_Data_Out, mon_e.wdata);
                    end
                end
            end
            if (bus.LSU_Resp_Valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL resp_unexpected: Resp_Valid with nothing outstanding (t=%0t)", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_data", bus.LSU_Resp_Data, mon_e.rdata);
                    check("resp_error", bus.LSU_Resp_Error, mon_e.err);
                    check("resp_latency_edges", cyc - mon_e.acc_cyc, mon_e.resp_edges);
                end
            end
        end
    end

    task automatic junk();
        bus.LSU_Req_Store  = 1'($urandom);
        bus.LSU_Req_Funct3 = 3'($urandom);
        bus.LSU_Req_Base   = $urandom;
        bus.LSU_Req_Offset = $urandom;
        bus.LSU_Req_Wdata  = $urandom;
    endtask

    // Drives one request; while the unit is busy the fields churn (with Valid kept high in hold mode).
    task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] base, input logic [31:0] off,
                         input logic [31:0] wd, input bit hold, input bit live);
        exp_t e;
        int   busy;
        bit   got;
        busy = 0;
        got  = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (bus.LSU_Req_Ready) begin
                bus.LSU_Req_Valid  = 1'b1;
                bus.LSU_Req_Store  = st;
                bus.LSU_Req_Funct3 = f3;
                bus.LSU_Req_Base   = base;
                bus.LSU_Req_Offset = off;
                bus.LSU_Req_Wdata  = wd;
                got = 1'b1;
            end else begin
                busy++;
                junk();
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL req_accept_timeout: Req_Ready stayed low for 40 cycles (t=%0t)", $time);
            bus.LSU_Req_Valid = 1'b0;
            b2b = 1'b0;
            return;
        end
        if (b2b) check("ready_low_cycles", busy, exp_busy);
        @(posedge clk);
        #1;
        e = model(st, f3, base, off, wd, live);
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        exp_busy = e.resp_edges + 1;
        b2b = 1'b1;
        if (!hold) bus.LSU_Req_Valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.LSU_Req_Valid = 1'b0;
        repeat (n) @(negedge clk);
        b2b = 1'b0;
    endtask

    // Aborts a word access at 0x180 mid-flight: in STORE, or in LOAD_DATA for a load.
    task automatic reset_abort(input bit st);
        issue(st, 3'b010, 32'h0000_0180, 32'h0, $urandom, 1'b0, 1'b0);
        if (!st) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check(st ? "reset_during_store" : "reset_during_load_data", outs(), RESET_OUTS);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        b2b = 1'b0;
    endtask

    bit          r_st;
    bit          r_hold;
    logic [2:0]  r_f3;
    logic [31:0] r_base, r_off;
    int          load_f3 [5] = '{0, 1, 2, 4, 5};

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) begin
            dev_mem[i] = 8'($urandom);
            ref_mem[i] = dev_mem[i];
        end
        bus.LSU_Req_Valid   = 1'b0;
        bus.LSU_Mem_Data_In = 32'd0;
        junk();

        #1 rst = 1'b1;
        #2;
        check("reset_outputs", outs(), RESET_OUTS);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", outs(), RESET_OUTS);

        // Word store then load back.
        issue(1'b1, 3'b010, 32'h100, 32'h4, 32'hDEAD_BEEF, 1'b0, 1'b1);
        issue(1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 1'b0, 1'b1);
        // Byte store, then signed and unsigned byte loads.
        issue(1'b1, 3'b000, 32'h203, 32'h0, 32'h1234_5680, 1'b0, 1'b1);
        issue(1'b0, 3'b000, 32'h203, 32'h0, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 3'b100, 32'h203, 32'h0, 32'h0, 1'b0, 1'b1);
        // Half store, then signed and unsigned half loads.
        issue(1'b1, 3'b001, 32'h202, 32'h0, 32'h0000_F00D, 1'b0, 1'b1);
        issue(1'b0, 3'b001, 32'h202, 32'h0, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 3'b101, 32'h200, 32'h2, 32'h0, 1'b0, 1'b1);
        // Errors: misaligned half, misaligned word, out of range, illegal funct3, unsigned store.
        issue(1'b0, 3'b001, 32'h200, 32'h1, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 3'b010, 32'h100, 32'h2, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 3'b010, 32'h3F0, 32'h10, 32'hCAFE_F00D, 1'b0, 1'b1);
        issue(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 3'b100, 32'h100, 32'h0, 32'h55, 1'b0, 1'b1);
        // EA wraps modulo 2^32 back into range; last byte of memory.
        issue(1'b0, 3'b010, 32'hFFFF_FFF0, 32'h20, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 3'b000, 32'h400, 32'hFFFF_FFFF, 32'hA5, 1'b0, 1'b1);
        issue(1'b0, 3'b000, 32'h3FF, 32'h0, 32'h0, 1'b0, 1'b1);

        // Valid held high through a load with changing fields.
        idle(2);
        issue(1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 1'b1, 1'b1);
        issue(1'b1, 3'b010, 32'h300, 32'hFFFF_FFFC, 32'h0BAD_CAFE, 1'b1, 1'b1);
        issue(1'b0, 3'b010, 32'h2FC, 32'h0, 32'h0, 1'b0, 1'b1);

        // Reset in LOAD_DATA and in STORE, each followed by a normal word load.
        reset_abort(1'b0);
        issue(1'b0, 3'b010, 32'h180, 32'h0, 32'h0, 1'b0, 1'b1);
        reset_abort(1'b1);
        issue(1'b0, 3'b010, 32'h180, 32'h0, 32'h0, 1'b0, 1'b1);

        for (int k = 0; k < 200; k++) begin
            r_st = 1'($urandom);
            if ($urandom_range(0, 9) == 0) r_f3 = 3'($urandom);
            else if (r_st)                 r_f3 = 3'($urandom_range(0, 2));
            else                           r_f3 = 3'(load_f3[$urandom_range(0, 4)]);
            r_base = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 1100));
            r_off  = 32'($urandom_range(0, 128)) - 32'd64;
            if ($urandom_range(0, 3) != 0) begin
                r_base = r_base & ~32'h3;
                r_off  = r_off & ~32'h3;
            end
            r_hold = ($urandom_range(0, 3) == 0);
            issue(r_st, r_f3, r_base, r_off, $urandom, r_hold, 1'b1);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end

        idle(10);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
